// File: rtl/iq_free_list_pkg.sv
// Shared IQ definitions: index type and lane-width constants used by the
// free list and the IQ payload RAM.
package iq_free_list_pkg;

    localparam int IQ_DEPTH          = 32;
    localparam int IQ_INDEX          = 5;
    localparam int IQ_DISPATCH_WIDTH = 4;
    localparam int IQ_ISSUE_WIDTH    = 4;

    typedef logic [IQ_INDEX-1:0] iq_idx_t;

endpackage : iq_free_list_pkg

// File: rtl/iq_free_compact.sv
// Free-lane compaction: turns a sparse per-lane free mask into dense write
// offsets (ascending lane order) and the total number of freed entries.
module iq_free_compact
    import iq_free_list_pkg::*;
#(
    parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH,
    parameter int CNT_W       = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic [ISSUE_WIDTH-1:0]            free_en,
    output logic [ISSUE_WIDTH-1:0][CNT_W-1:0] free_offset,
    output logic [CNT_W-1:0]                  n_free
);

    logic [CNT_W-1:0] run_s;

    // Exclusive prefix count of asserted lanes gives each lane its slot offset
    always_comb begin
        run_s       = {CNT_W{1'b0}};
        free_offset = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            free_offset[j] = run_s;
            run_s          = run_s + CNT_W'(free_en[j]);
        end
        n_free = run_s;
    end

endmodule : iq_free_compact

// File: rtl/iq_free_list.sv
// Issue-queue free list: circular list of free IQ entry indices. Dispatch
// lanes take entries from the head, issue lanes return entries at the tail.
// Optional checker: define IQ_FREE_LIST_CHECK_EN to add the sticky error_o
// output flagging free overflow, non-contiguous alloc, or alloc while stalled.
module iq_free_list
    import iq_free_list_pkg::*;
#(
    parameter int DEPTH          = IQ_DEPTH,
    parameter int INDEX          = IQ_INDEX,
    parameter int DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH    = IQ_ISSUE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DISPATCH_WIDTH-1:0]            allocEn_i,
    output logic [DISPATCH_WIDTH-1:0][INDEX-1:0] allocIdx_o,
    input  logic [ISSUE_WIDTH-1:0]               freeEn_i,
    input  logic [ISSUE_WIDTH-1:0][INDEX-1:0]    freeIdx_i,
    output logic [INDEX:0]                       freeCnt_o,
    output logic                                 stall_o
`ifdef IQ_FREE_LIST_CHECK_EN
    ,
    output logic                                 error_o
`endif
);

    localparam int CW     = INDEX + 1;
    localparam int ACNT_W = $clog2(DISPATCH_WIDTH + 1);
    localparam int FCNT_W = $clog2(ISSUE_WIDTH + 1);

    logic [INDEX-1:0]                    list_r [DEPTH];
    logic [INDEX-1:0]                    head_r;
    logic [INDEX-1:0]                    tail_r;
    logic [CW-1:0]                       count_r;

    logic                                stall_s;
    logic [ACNT_W-1:0]                   n_alloc_s;
    logic [ISSUE_WIDTH-1:0][FCNT_W-1:0]  free_offset_s;
    logic [FCNT_W-1:0]                   n_free_s;
    logic [CW-1:0]                       count_next_s;

    iq_free_compact #(
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .CNT_W       (FCNT_W)
    ) u_compact (
        .free_en     (freeEn_i),
        .free_offset (free_offset_s),
        .n_free      (n_free_s)
    );

    // Stall depends only on the registered count, never on this cycle's requests
    assign stall_s   = (count_r < CW'(DISPATCH_WIDTH));
    assign stall_o   = stall_s;
    assign freeCnt_o = count_r;

    // Granted allocation count: zero while stalled, else number of request lanes
    always_comb begin
        n_alloc_s = {ACNT_W{1'b0}};
        if (!stall_s) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                n_alloc_s = n_alloc_s + ACNT_W'(allocEn_i[k]);
            end
        end else begin
            n_alloc_s = {ACNT_W{1'b0}};
        end
    end

    // Next occupancy combines both same-cycle allocation and release
    always_comb begin
        count_next_s = count_r - CW'(n_alloc_s) + CW'(n_free_s);
    end

    // Offer the next DISPATCH_WIDTH free entries starting at the head
    always_comb begin
        allocIdx_o = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            allocIdx_o[k] = list_r[head_r + INDEX'(k)];
        end
    end

    // List storage, pointers and count; freed entries land at the tail next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                list_r[i] <= INDEX'(i);
            end
            head_r  <= {INDEX{1'b0}};
            tail_r  <= {INDEX{1'b0}};
            count_r <= CW'(DEPTH);
        end else begin
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (freeEn_i[j]) begin
                    list_r[tail_r + INDEX'(free_offset_s[j])] <= freeIdx_i[j];
                end
            end
            head_r  <= head_r + INDEX'(n_alloc_s);
            tail_r  <= tail_r + INDEX'(n_free_s);
            count_r <= count_next_s;
        end
    end

`ifdef IQ_FREE_LIST_CHECK_EN
    logic error_r;
    logic overflow_s;
    logic non_contig_s;
    logic alloc_stall_s;

    // Protocol violation detection on the current cycle's requests
    always_comb begin
        overflow_s    = ({1'b0, count_r} + (CW + 1)'(n_free_s)) > (CW + 1)'(DEPTH);
        non_contig_s  = ((allocEn_i & (allocEn_i + DISPATCH_WIDTH'(1))) != {DISPATCH_WIDTH{1'b0}});
        alloc_stall_s = stall_s && (allocEn_i != {DISPATCH_WIDTH{1'b0}});
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            error_r <= 1'b0;
        end else if (overflow_s || non_contig_s || alloc_stall_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign error_o = error_r;
`endif

endmodule : iq_free_list

// File: tb/tb_iq_free_list.sv
// Self-checking bench for iq_free_list. A reference queue of free indices is
// filled on reset/free and popped whenever the DUT offers entries to dispatch.
module tb_iq_free_list;

    localparam int DEPTH = 32;
    localparam int INDEX = 5;
    localparam int DW    = 4;
    localparam int IW    = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [DW-1:0]            allocEn_i;
    logic [DW-1:0][INDEX-1:0] allocIdx_o;
    logic [IW-1:0]            freeEn_i;
    logic [IW-1:0][INDEX-1:0] freeIdx_i;
    logic [INDEX:0]           freeCnt_o;
    logic                     stall_o;
`ifdef IQ_FREE_LIST_CHECK_EN
    logic                     error_o;
`endif

    int checks   = 0;
    int failures = 0;
    int fq[$];     // expected free list, head first
    int outq[$];   // entries currently held by the IQ

    iq_free_list #(
        .DEPTH          (DEPTH),
        .INDEX          (INDEX),
        .DISPATCH_WIDTH (DW),
        .ISSUE_WIDTH    (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .allocEn_i  (allocEn_i),
        .allocIdx_o (allocIdx_o),
        .freeEn_i   (freeEn_i),
        .freeIdx_i  (freeIdx_i),
        .freeCnt_o  (freeCnt_o),
        .stall_o    (stall_o)
`ifdef IQ_FREE_LIST_CHECK_EN
        ,
        .error_o    (error_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        fq.delete();
        outq.delete();
        for (int i = 0; i < DEPTH; i++) fq.push_back(i);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        allocEn_i = '0;
        freeEn_i  = '0;
        freeIdx_i = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pick_out(output logic [INDEX-1:0] v);
        int pos;
        pos = $urandom_range(0, outq.size() - 1);
        v   = INDEX'(outq[pos]);
        outq.delete(pos);
    endtask

    task automatic remove_out(input int v);
        for (int i = 0; i < outq.size(); i++) begin
            if (outq[i] == v) begin
                outq.delete(i);
                break;
            end
        end
    endtask

    // One cycle: drive, check outputs against the model, advance the model
    task automatic step(input logic [DW-1:0] aen, input logic [IW-1:0] fen,
                        input logic [IW-1:0][INDEX-1:0] fidx);
        int  n;
        int  exp;
        logic stall_m;
        allocEn_i = aen;
        freeEn_i  = fen;
        freeIdx_i = fidx;
        stall_m   = (fq.size() < DW);
        checks++;
        if (freeCnt_o !== (INDEX + 1)'(fq.size())) begin
            failures++;
            $display("FAIL freeCnt: got %0d expected %0d", freeCnt_o, fq.size());
        end
        checks++;
        if (stall_o !== stall_m) begin
            failures++;
            $display("FAIL stall: got %0b expected %0b", stall_o, stall_m);
        end
        n = 0;
        for (int k = 0; k < DW; k++) n += int'(aen[k]);
        if (!stall_m) begin
            for (int k = 0; k < n; k++) begin
                exp = fq.pop_front();
                outq.push_back(exp);
                checks++;
                if (allocIdx_o[k] !== INDEX'(exp)) begin
                    failures++;
                    $display("FAIL allocIdx[%0d]: got %0d expected %0d", k, allocIdx_o[k], exp);
                end
            end
        end
        for (int j = 0; j < IW; j++) begin
            if (fen[j]) fq.push_back(int'(fidx[j]));
        end
        @(posedge clk); #1;
        allocEn_i = '0;
        freeEn_i  = '0;
        freeIdx_i = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (freeCnt_o !== 6'd32) begin
            failures++;
            $display("FAIL reset_cnt: got %0d expected 32", freeCnt_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %0b expected 0", stall_o);
        end
        for (int k = 0; k < DW; k++) begin
            checks++;
            if (allocIdx_o[k] !== INDEX'(k)) begin
                failures++;
                $display("FAIL reset_idx[%0d]: got %0d expected %0d", k, allocIdx_o[k], k);
            end
        end
    endtask

    task automatic test_alloc_basic();
        step(4'b1111, 4'b0000, '0);
        checks++;
        if (freeCnt_o !== 6'd28) begin
            failures++;
            $display("FAIL alloc_cnt: got %0d expected 28", freeCnt_o);
        end
        for (int k = 0; k < DW; k++) begin
            checks++;
            if (allocIdx_o[k] !== INDEX'(k + 4)) begin
                failures++;
                $display("FAIL alloc_next[%0d]: got %0d expected %0d", k, allocIdx_o[k], k + 4);
            end
        end
    endtask

    task automatic test_drain();
        for (int c = 0; c < 7; c++) step(4'b1111, 4'b0000, '0);
        checks++;
        if (freeCnt_o !== 6'd0 || stall_o !== 1'b1) begin
            failures++;
            $display("FAIL drain: got cnt=%0d stall=%0b expected cnt=0 stall=1", freeCnt_o, stall_o);
        end
        step(4'b1111, 4'b0000, '0);
        checks++;
        if (freeCnt_o !== 6'd0) begin
            failures++;
            $display("FAIL stalled_alloc: got %0d expected 0", freeCnt_o);
        end
    endtask

    task automatic test_free_sparse();
        logic [IW-1:0][INDEX-1:0] fidx;
        fidx    = '0;
        fidx[1] = 5'd9;
        fidx[3] = 5'd17;
        remove_out(9);
        remove_out(17);
        step(4'b0000, 4'b1010, fidx);
        checks++;
        if (freeCnt_o !== 6'd2 || stall_o !== 1'b1) begin
            failures++;
            $display("FAIL sparse_cnt: got cnt=%0d stall=%0b expected cnt=2 stall=1", freeCnt_o, stall_o);
        end
        checks++;
        if (allocIdx_o[0] !== 5'd9 || allocIdx_o[1] !== 5'd17) begin
            failures++;
            $display("FAIL sparse_order: got %0d,%0d expected 9,17", allocIdx_o[0], allocIdx_o[1]);
        end
    endtask

    task automatic test_same_cycle();
        logic [IW-1:0][INDEX-1:0] fidx;
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < IW; j++) pick_out(fidx[j]);
            step(4'b0000, 4'b1111, fidx);
        end
        checks++;
        if (freeCnt_o !== 6'd10) begin
            failures++;
            $display("FAIL pre_same_cnt: got %0d expected 10", freeCnt_o);
        end
        for (int j = 0; j < IW; j++) pick_out(fidx[j]);
        step(4'b0011, 4'b1111, fidx);
        checks++;
        if (freeCnt_o !== 6'd12) begin
            failures++;
            $display("FAIL same_cnt: got %0d expected 12", freeCnt_o);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0]            aen;
        logic [IW-1:0]            fen;
        logic [IW-1:0][INDEX-1:0] fidx;
        int                       na;
        for (int c = 0; c < 100; c++) begin
            na   = (fq.size() >= DW) ? int'($urandom_range(0, DW)) : 0;
            aen  = DW'((1 << na) - 1);
            fen  = IW'($urandom_range(0, 15));
            fidx = '0;
            for (int j = 0; j < IW; j++) begin
                if (fen[j]) begin
                    if (outq.size() > 0) pick_out(fidx[j]);
                    else fen[j] = 1'b0;
                end
            end
            step(aen, fen, fidx);
        end
        // drain what is left so every remaining free index is compared
        for (int c = 0; c < 10 && fq.size() >= DW; c++) step(4'b1111, 4'b0000, '0);
        checks++;
        if (freeCnt_o !== (INDEX + 1)'(DEPTH - outq.size())) begin
            failures++;
            $display("FAIL random_total: got %0d expected %0d", freeCnt_o, DEPTH - outq.size());
        end
    endtask

`ifdef IQ_FREE_LIST_CHECK_EN
    task automatic test_error();
        do_reset();
        checks++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got %0b expected 0", error_o);
        end
        allocEn_i = 4'b0101;
        @(posedge clk); #1;
        allocEn_i = '0;
        checks++;
        if (error_o !== 1'b1) begin
            failures++;
            $display("FAIL err_noncontig: got %0b expected 1", error_o);
        end
        do_reset();
        freeEn_i     = 4'b0001;
        freeIdx_i[0] = 5'd5;
        @(posedge clk); #1;
        freeEn_i  = '0;
        freeIdx_i = '0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (error_o !== 1'b1) begin
                failures++;
                $display("FAIL err_overflow_hold%0d: got %0b expected 1", c, error_o);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_reset_mid_traffic();
        logic [IW-1:0][INDEX-1:0] fidx;
        do_reset();
        step(4'b1111, 4'b0000, '0);
        step(4'b1111, 4'b0000, '0);
        for (int j = 0; j < IW; j++) pick_out(fidx[j]);
        reset     = 1'b1;
        allocEn_i = 4'b1111;
        freeEn_i  = 4'b1111;
        freeIdx_i = fidx;
        @(posedge clk); #1;
        reset     = 1'b0;
        allocEn_i = '0;
        freeEn_i  = '0;
        freeIdx_i = '0;
        model_reset();
        checks++;
        if (freeCnt_o !== 6'd32 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got cnt=%0d stall=%0b expected cnt=32 stall=0", freeCnt_o, stall_o);
        end
        for (int k = 0; k < DW; k++) begin
            checks++;
            if (allocIdx_o[k] !== INDEX'(k)) begin
                failures++;
                $display("FAIL mid_reset_idx[%0d]: got %0d expected %0d", k, allocIdx_o[k], k);
            end
        end
`ifdef IQ_FREE_LIST_CHECK_EN
        checks++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_err: got %0b expected 0", error_o);
        end
`endif
        step(4'b1111, 4'b0000, '0);
        step(4'b0000, 4'b0000, '0);
    endtask

    initial begin
        reset     = 1'b1;
        allocEn_i = '0;
        freeEn_i  = '0;
        freeIdx_i = '0;
        test_reset();
        test_alloc_basic();
        test_drain();
        test_free_sparse();
        test_same_cycle();
        test_random();
`ifdef IQ_FREE_LIST_CHECK_EN
        test_error();
`endif
        test_reset_mid_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_iq_free_list

// File: doc/iq_free_list.md
IQ_FREE_LIST -- requirements
Module: iq_free_list

Interface
REQ-001 Parameter DEPTH, default 32: number of IQ entries; SHALL be a power of two.
REQ-002 Parameter INDEX, default 5: IQ entry index width; SHALL equal log2(DEPTH).
REQ-003 Parameter DISPATCH_WIDTH, default 4: number of allocation lanes.
REQ-004 Parameter ISSUE_WIDTH, default 4: number of free (issue) lanes.
REQ-005 clk  input  1: clock; all state changes on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 allocEn_i  input  DISPATCH_WIDTH: per-lane allocation request; asserted lanes SHALL be contiguous from lane 0.
REQ-008 allocIdx_o  output  DISPATCH_WIDTH x INDEX: entry index offered to each dispatch lane; drives the payload RAM write address.
REQ-009 freeEn_i  input  ISSUE_WIDTH: per-lane release of an issued entry; any lane pattern is legal.
REQ-010 freeIdx_i  input  ISSUE_WIDTH x INDEX: entry index released on each lane.
REQ-011 freeCnt_o  output  INDEX+1: number of free entries, registered.
REQ-012 stall_o  output  1: asserted when freeCnt_o < DISPATCH_WIDTH.

Function
REQ-013 The block SHALL hold a circular list of DEPTH index slots with registered headPtr, tailPtr (INDEX bits each) and count (INDEX+1 bits).
REQ-014 allocIdx_o[k] SHALL be combinationally equal to list[(headPtr+k) mod DEPTH], valid when stall_o is low.
REQ-015 Alloc is granted only when stall_o is low; nAlloc = popcount(allocEn_i); headPtr advances by nAlloc mod DEPTH next cycle.
REQ-016 When stall_o is high, allocEn_i SHALL be ignored: no pointer or count change from allocation.
REQ-017 Asserted free lanes SHALL be compacted in ascending lane order and written to list[(tailPtr+j) mod DEPTH], j = 0..nFree-1; tailPtr advances by nFree.
REQ-018 Same-cycle alloc and free: count_next = count - nAlloc + nFree; both pointer updates apply.
REQ-019 An entry freed in cycle N SHALL not appear on allocIdx_o before cycle N+1.
REQ-020 Pointer arithmetic SHALL wrap modulo DEPTH with no extra wrap bit; fullness is determined solely by count.
REQ-021 Freeing when count + nFree > DEPTH, or freeing an index already free, is illegal; the list state is then undefined except as defined in REQ-026.
REQ-022 stall_o and freeCnt_o SHALL derive only from the registered count, with no combinational path from allocEn_i or freeEn_i.

Reset
REQ-023 On reset: list[i] = i for i = 0..DEPTH-1, headPtr = 0, tailPtr = 0, count = DEPTH.
REQ-024 After reset: freeCnt_o = DEPTH, stall_o = 0, allocIdx_o[k] = k.
REQ-025 Reset asserted mid-operation SHALL override all same-cycle alloc and free activity.

Configuration
REQ-026 With IQ_FREE_LIST_CHECK_EN defined, the block SHALL add output error_o (1 bit). error_o is sticky, clears only on reset, and sets on any of:
- a free that would overflow;
- allocEn_i non-contiguous;
- allocEn_i nonzero while stall_o is high.
REQ-027 Without IQ_FREE_LIST_CHECK_EN, error_o and its logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-028 A shared package SHALL hold the IQ index typedef (INDEX bits) and the DISPATCH_WIDTH/ISSUE_WIDTH constants, used by this block and the IQ payload RAM.
REQ-029 One sub-module, iq_free_compact, SHALL perform lane compaction and popcount for the free lanes, producing per-lane write offsets and nFree.

Verification
REQ-030 Reset, then allocEn_i=4'b1111 -> allocIdx_o = 0,1,2,3; next cycle freeCnt_o = 28 and allocIdx_o = 4,5,6,7.
REQ-031 Alloc 8 cycles x 4 lanes from reset -> freeCnt_o = 0, stall_o = 1; a further alloc is ignored and freeCnt_o stays 0.
REQ-032 With count = 0, freeEn_i = 4'b1010 and freeIdx_i lanes 1 and 3 = 9 and 17 -> next cycle freeCnt_o = 2, stall_o = 1; list holds 9 then 17 at headPtr.
REQ-033 Same cycle, count = 10: allocEn_i = 4'b0011 and freeEn_i = 4'b1111 -> next cycle freeCnt_o = 12; freed indices are not offered in the same cycle.
REQ-034 Run 100 cycles of random alloc/free traffic so that headPtr and tailPtr wrap past 31 -> no index is duplicated or lost; allocIdx_o sequence is checked against a reference queue.
REQ-035 With IQ_FREE_LIST_CHECK_EN: a free while count = 32 -> error_o = 1 and holds until reset; then assert reset mid-traffic -> state per REQ-023 and error_o = 0.
